// File: rtl/if_branch_predictor_gshare_ckpt.sv
// GShare direction predictor for IF with speculative global history and per-query history checkpoints.
// The PHT is cleared sequentially after reset, so the table has no reset and can map onto RAM.
module if_branch_predictor_gshare_ckpt #(
  parameter int         IDX_BITS  = 10,
  parameter int         HIST_BITS = 10,
  parameter int         PC_LSB    = 2,
  parameter logic [1:0] CTR_INIT  = 2'b11
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pred_ready,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_take,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 fb_valid,
  input  logic [31:0]          fb_pc,
  input  logic [HIST_BITS-1:0] fb_ghr,
  input  logic                 fb_take,
  input  logic                 fb_mispredict,
  output logic [31:0]          perf_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state, state_nxt;
  logic [IDX_BITS-1:0]  init_idx, init_idx_nxt;
  logic [HIST_BITS-1:0] spec_ghr, spec_ghr_nxt;
  logic [31:0]          perf_nxt;

  logic [1:0]           pht [ENTRIES];
  logic [IDX_BITS-1:0]  pred_idx, fb_idx, wr_idx;
  logic [1:0]           pred_ctr, fb_ctr, fb_ctr_trained, wr_dat;
  logic                 wr_en;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc, fb_pc};

  assign pred_idx = pred_pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(spec_ghr);
  assign fb_idx   = fb_pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(fb_ghr);
  assign pred_ctr = pht[pred_idx];
  assign fb_ctr   = pht[fb_idx];
  assign pred_ready = (state == RUN);

  always_comb begin
    fb_ctr_trained = fb_ctr;
    if (fb_take && fb_ctr != 2'b11)
      fb_ctr_trained = fb_ctr + 2'b01;
    else if (!fb_take && fb_ctr != 2'b00)
      fb_ctr_trained = fb_ctr - 2'b01;
  end

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    spec_ghr_nxt = spec_ghr;
    perf_nxt     = perf_mispredicts;
    wr_en        = 1'b0;
    wr_idx       = fb_idx;
    wr_dat       = fb_ctr_trained;
    pred_take    = 1'b0;
    pred_ghr     = '0;
    case (state)
      INIT: begin
        wr_en        = 1'b1;
        wr_idx       = init_idx;
        wr_dat       = CTR_INIT;
        init_idx_nxt = init_idx + 1'b1;
        if (&init_idx)
          state_nxt = RUN;
      end
      RUN: begin
        pred_take = pred_ctr[1];
        pred_ghr  = spec_ghr;
        // Mispredict restore is assigned last so it overrides the speculative shift.
        if (pred_valid)
          spec_ghr_nxt = HIST_BITS'({spec_ghr, pred_ctr[1]});
        if (fb_valid) begin
          wr_en = 1'b1;
          if (fb_mispredict) begin
            spec_ghr_nxt = HIST_BITS'({fb_ghr, fb_take});
            if (perf_mispredicts != '1)
              perf_nxt = perf_mispredicts + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= INIT;
      init_idx         <= '0;
      spec_ghr         <= '0;
      perf_mispredicts <= '0;
    end else begin
      state            <= state_nxt;
      init_idx         <= init_idx_nxt;
      spec_ghr         <= spec_ghr_nxt;
      perf_mispredicts <= perf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      pht[wr_idx] <= wr_dat;
  end

endmodule

// File: tb/tb_if_branch_predictor_gshare_ckpt.sv
// Bench for the GShare predictor: a counter/history reference model feeds an expectation queue
// that is drained against the combinational prediction outputs each cycle.
module tb_if_branch_predictor_gshare_ckpt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        fb_valid = 1'b0;
  logic [31:0] fb_pc = '0;
  logic [9:0]  fb_ghr = '0;
  logic        fb_take = 1'b0;
  logic        fb_mispredict = 1'b0;

  logic        pred_ready, pred_take;
  logic [9:0]  pred_ghr;
  logic [31:0] perf_mispredicts;
  logic        r01, t01;
  logic [9:0]  g01;
  logic [31:0] p01;

  int passed = 0;
  int total = 0;

  logic [1:0] m_pht [1024];
  logic [9:0] m_ghr;
  int         m_perf;
  logic       exp_take_q[$];
  logic [9:0] exp_ghr_q[$];

  always #5 clk = ~clk;

  if_branch_predictor_gshare_ckpt dut (
    .clk(clk), .reset(reset), .pred_ready(pred_ready), .pred_valid(pred_valid),
    .pred_pc(pred_pc), .pred_take(pred_take), .pred_ghr(pred_ghr), .fb_valid(fb_valid),
    .fb_pc(fb_pc), .fb_ghr(fb_ghr), .fb_take(fb_take), .fb_mispredict(fb_mispredict),
    .perf_mispredicts(perf_mispredicts)
  );

  if_branch_predictor_gshare_ckpt #(.CTR_INIT(2'b01)) dut01 (
    .clk(clk), .reset(reset), .pred_ready(r01), .pred_valid(pred_valid),
    .pred_pc(pred_pc), .pred_take(t01), .pred_ghr(g01), .fb_valid(fb_valid),
    .fb_pc(fb_pc), .fb_ghr(fb_ghr), .fb_take(fb_take), .fb_mispredict(fb_mispredict),
    .perf_mispredicts(p01)
  );

  function automatic logic [9:0] idx(input logic [31:0] pc, input logic [9:0] g);
    return pc[11:2] ^ g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 2'b11;
    m_ghr = '0;
    m_perf = 0;
    exp_take_q.delete();
    exp_ghr_q.delete();
  endtask

  // Drives one cycle of stimulus at the falling edge and advances the model to its post-edge state.
  task automatic drive(input logic pv, input logic [31:0] ppc, input logic fv, input logic [31:0] fpc,
                       input logic [9:0] fg, input logic ft, input logic fm);
    logic [1:0] c;
    logic       t;
    logic [9:0] fi;
    @(negedge clk);
    pred_valid = pv; pred_pc = ppc; fb_valid = fv; fb_pc = fpc;
    fb_ghr = fg; fb_take = ft; fb_mispredict = fm;
    t = m_pht[idx(ppc, m_ghr)][1];
    exp_take_q.push_back(t);
    exp_ghr_q.push_back(m_ghr);
    if (pv) m_ghr = {m_ghr[8:0], t};
    if (fv) begin
      fi = idx(fpc, fg);
      c = m_pht[fi];
      if (ft) m_pht[fi] = (c == 2'b11) ? 2'b11 : c + 2'b01;
      else    m_pht[fi] = (c == 2'b00) ? 2'b00 : c - 2'b01;
      if (fm) begin
        m_ghr = {fg[8:0], ft};
        m_perf++;
      end
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    while (!pred_ready && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      #1;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'hFFC;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({pred_ready, pred_take, pred_ghr, perf_mispredicts} !== '0)
      $display("FAIL reset_outputs: got ready=%0b take=%0b ghr=%h perf=%0d, want all 0",
               pred_ready, pred_take, pred_ghr, perf_mispredicts);
    else passed++;
    model_reset();
    // Queries and feedback during init must be ignored.
    pred_valid = 1'b1; fb_valid = 1'b1; fb_mispredict = 1'b1; fb_ghr = 10'h155; fb_take = 1'b1;
    wait_ready(cnt);
    total++;
    if (cnt !== 1024) $display("FAIL init_cycles: got %0d, want 1024", cnt);
    else passed++;
    total++;
    if (r01 !== 1'b1) $display("FAIL init01_ready: got %0b, want 1", r01);
    else passed++;
    pred_valid = 1'b0; fb_valid = 1'b0; fb_mispredict = 1'b0;
    #1;
    total++;
    if (pred_ghr !== 10'h0 || perf_mispredicts !== 32'd0)
      $display("FAIL init_ignored: got ghr=%h perf=%0d, want 0/0", pred_ghr, perf_mispredicts);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      pred_pc = pcs[i];
      #1;
      total++;
      if (t01 !== 1'b0 || pred_take !== 1'b1)
        $display("FAIL init_value pc=%h: got take01=%0b take=%0b, want 0/1", pcs[i], t01, pred_take);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    logic want [6];
    want[0] = 1; want[1] = 1; want[2] = 0; want[3] = 0; want[4] = 0; want[5] = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h100, i < 5, 32'h100, 10'h0, i == 4, 1'b0);
      #1;
      total++;
      if (pred_take !== exp_take_q.pop_front() || pred_take !== want[i])
        $display("FAIL saturation step %0d: got take=%0b, want %0b", i, pred_take, want[i]);
      else passed++;
      void'(exp_ghr_q.pop_front());
    end
  endtask

  task automatic test_spec_history();
    logic [9:0] want [4];
    logic [9:0] eg;
    want[0] = 10'h000; want[1] = 10'h001; want[2] = 10'h003; want[3] = 10'h007;
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'h200 + 32'(4 * i), 1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      #1;
      eg = exp_ghr_q.pop_front();
      total++;
      if (pred_ghr !== eg || pred_ghr !== want[i] || pred_take !== exp_take_q.pop_front())
        $display("FAIL spec_history step %0d: got ghr=%h take=%0b, want ghr=%h", i, pred_ghr, pred_take, want[i]);
      else passed++;
    end
  endtask

  task automatic test_mispredict();
    drive(1'b1, 32'h300, 1'b1, 32'h400, 10'h005, 1'b0, 1'b1);
    #1;
    void'(exp_take_q.pop_front()); void'(exp_ghr_q.pop_front());
    drive(1'b0, 32'h300, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
    #1;
    void'(exp_take_q.pop_front());
    total++;
    if (pred_ghr !== exp_ghr_q.pop_front() || pred_ghr !== 10'h00A)
      $display("FAIL mispredict_restore: got ghr=%h, want 00a", pred_ghr);
    else passed++;
    total++;
    if (perf_mispredicts !== 32'(m_perf) || perf_mispredicts !== 32'd1)
      $display("FAIL mispredict_count: got %0d, want 1", perf_mispredicts);
    else passed++;
  endtask

  task automatic test_collision();
    logic want [3];
    want[0] = 1; want[1] = 1; want[2] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h500, i < 2, 32'h500, 10'h00A, 1'b0, 1'b0);
      #1;
      void'(exp_ghr_q.pop_front());
      total++;
      if (pred_take !== exp_take_q.pop_front() || pred_take !== want[i])
        $display("FAIL collision step %0d: got take=%0b, want %0b", i, pred_take, want[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    logic et;
    logic [9:0] eg;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 63)), 2'b00},
            1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 63)), 2'b00},
            10'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
      #1;
      et = exp_take_q.pop_front();
      eg = exp_ghr_q.pop_front();
      total++;
      if (pred_take !== et || pred_ghr !== eg) begin
        $display("FAIL back_to_back cycle %0d: got take=%0b ghr=%h, want take=%0b ghr=%h",
                 i, pred_take, pred_ghr, et, eg);
        bad++;
      end else passed++;
      if (bad > 5) break;
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
    #1;
    void'(exp_take_q.pop_front()); void'(exp_ghr_q.pop_front());
    total++;
    if (perf_mispredicts !== 32'(m_perf))
      $display("FAIL back_to_back_perf: got %0d, want %0d", perf_mispredicts, m_perf);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    int bad, bad01;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (pred_ready !== 1'b0 || pred_ghr !== 10'h0)
      $display("FAIL reset_mid_init: got ready=%0b ghr=%h, want 0/0", pred_ready, pred_ghr);
    else passed++;
    model_reset();
    wait_ready(cnt);
    total++;
    if (cnt !== 1024) $display("FAIL reinit_cycles_a: got %0d, want 1024", cnt);
    else passed++;
    drive(1'b0, 32'h0, 1'b1, 32'h800, 10'h1FF, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b0, 32'h0, 1'b1, 32'h900, 10'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      void'(exp_take_q.pop_front()); void'(exp_ghr_q.pop_front());
    end
    total++;
    if (pred_ghr !== exp_ghr_q.pop_front() || pred_ghr !== 10'h3FF || pred_take !== exp_take_q.pop_front()
        || pred_take !== 1'b1 || perf_mispredicts !== 32'd1)
      $display("FAIL pre_reset_state: got ghr=%h take=%0b perf=%0d, want 3ff/1/1", pred_ghr, pred_take, perf_mispredicts);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({pred_ready, pred_take, pred_ghr, perf_mispredicts} !== '0)
      $display("FAIL reset_mid_run: got ready=%0b take=%0b ghr=%h perf=%0d, want all 0",
               pred_ready, pred_take, pred_ghr, perf_mispredicts);
    else passed++;
    model_reset();
    wait_ready(cnt);
    total++;
    if (cnt !== 1024) $display("FAIL reinit_cycles_b: got %0d, want 1024", cnt);
    else passed++;
    bad = 0; bad01 = 0;
    for (int i = 0; i < 1024; i++) begin
      pred_pc = 32'(i) << 2;
      #1;
      if (pred_take !== 1'b1) bad++;
      if (t01 !== 1'b0) bad01++;
    end
    total++;
    if (bad !== 0) $display("FAIL reinit_table: got %0d entries not taken, want 0", bad);
    else passed++;
    total++;
    if (bad01 !== 0) $display("FAIL init01_table: got %0d entries taken, want 0", bad01);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_spec_history();
    test_mispredict();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
